// File: rtl/shift_ctrl.sv
// Shift-register control front-end: prescaled shift tick plus a debounced,
// tick-aligned reverse request from a raw push-button.
module shift_ctrl #(
    parameter int unsigned NB_COUNT   = 32,
    parameter int unsigned PERIOD_0   = 2**22 - 1,
    parameter int unsigned PERIOD_1   = 2**23 - 1,
    parameter int unsigned PERIOD_2   = 2**24 - 1,
    parameter int unsigned PERIOD_3   = 2**25 - 1,
    parameter int unsigned NB_DEB     = 20,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_sel,
    input  logic       i_btn,
    output logic       o_valid,
    output logic       o_reverse,
    output logic       o_btn_clean
);

    typedef enum logic [1:0] {StLow, StRise, StHigh, StFall} deb_state_e;

    localparam logic [NB_DEB:0] DEB_LAST = (NB_DEB + 1)'(DEB_CYCLES - 1);

    logic                btn_meta_q;
    logic                btn_s_q;
    deb_state_e          state_q, state_d;
    logic [NB_DEB-1:0]   deb_cnt_q, deb_cnt_d;
    logic                deb_done;
    logic                rise;
    logic [NB_COUNT-1:0] count_q, count_d;
    logic [NB_COUNT-1:0] limit;
    logic                terminal;
    logic                pending_q, pending_d;
    logic                valid_q;
    logic                reverse_q;

    // Level is accepted on the edge where the incremented count reaches DEB_CYCLES-1,
    // so the whole press-to-accept latency is 2 sync + DEB_CYCLES cycles.
    assign deb_done = ({1'b0, deb_cnt_q} + (NB_DEB + 1)'(1)) >= DEB_LAST;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        rise      = 1'b0;
        unique case (state_q)
            StLow: begin
                if (btn_s_q) begin
                    deb_cnt_d = '0;
                    state_d   = StRise;
                end
            end
            StRise: begin
                if (!btn_s_q) begin
                    state_d = StLow;
                end else begin
                    deb_cnt_d = deb_cnt_q + NB_DEB'(1);
                    if (deb_done) begin
                        state_d = StHigh;
                        rise    = 1'b1;
                    end
                end
            end
            StHigh: begin
                if (!btn_s_q) begin
                    deb_cnt_d = '0;
                    state_d   = StFall;
                end
            end
            StFall: begin
                if (btn_s_q) begin
                    state_d = StHigh;
                end else begin
                    deb_cnt_d = deb_cnt_q + NB_DEB'(1);
                    if (deb_done) begin
                        state_d = StLow;
                    end
                end
            end
            default: state_d = StLow;
        endcase
    end

    always_comb begin
        limit = NB_COUNT'(PERIOD_0);
        unique case (i_sel)
            2'd0: limit = NB_COUNT'(PERIOD_0);
            2'd1: limit = NB_COUNT'(PERIOD_1);
            2'd2: limit = NB_COUNT'(PERIOD_2);
            2'd3: limit = NB_COUNT'(PERIOD_3);
            default: limit = NB_COUNT'(PERIOD_0);
        endcase
    end

    // >= so a period shrink past the current count terminates instead of wrapping.
    assign terminal = i_enable && (count_q >= limit);

    always_comb begin
        count_d   = count_q;
        pending_d = pending_q;
        if (terminal) begin
            count_d = '0;
        end else if (i_enable) begin
            count_d = count_q + NB_COUNT'(1);
        end
        // A rise on a tick cycle is consumed by that tick.
        if (terminal) begin
            pending_d = 1'b0;
        end else if (rise) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            state_q    <= StLow;
            deb_cnt_q  <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            valid_q    <= 1'b0;
            reverse_q  <= 1'b0;
        end else begin
            btn_meta_q <= i_btn;
            btn_s_q    <= btn_meta_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            valid_q    <= terminal;
            reverse_q  <= terminal & (pending_q | rise);
        end
    end

    assign o_valid     = valid_q;
    assign o_reverse   = reverse_q;
    assign o_btn_clean = (state_q == StHigh) || (state_q == StFall);

endmodule
